// File: rtl/cq_viola_nios2_s_cpu_mult_seq.sv
// Sequencer for 32x32 Nios II multiplies on an external three-product 16x16 cell:
// one pass for MUL (low word), two passes for the MULX* high-word variants.
//
// state  | meaning
// IDLE   | waiting for a request
// ISSUE1 | pass 1 operands presented to the cell, cell enabled
// WAIT1  | pass 1 cell latency beyond the first cycle
// ISSUE2 | pass 1 products captured; MUL finishes, MULX* issues Ahi*Bhi
// WAIT2  | pass 2 latency; last cycle folds in Ahi*Bhi and corrects for sign
// DONE   | result held until consumed
module cq_viola_nios2_s_cpu_mult_seq #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [1:0]  in_op,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  localparam logic [1:0] WAIT1_LD = (MUL_LATENCY > 1) ? 2'(MUL_LATENCY - 2) : 2'd0;
  localparam logic [1:0] WAIT2_LD = 2'(MUL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [31:0] result_q, result_d;
  logic        up_q;

  logic [31:0] mul_lo;
  logic [32:0] mid_sum;
  logic [63:0] u_full;
  logic [31:0] u_hi;
  logic [31:0] hi_res;
  logic        u_lo_unused;

  assign mul_lo      = mul_p1 + ((mul_p2 + mul_p3) << 16);
  assign mid_sum     = {1'b0, p2_q} + {1'b0, p3_q};
  // In WAIT2 the cell's p1 output carries Ahi*Bhi, the top partial product.
  assign u_full      = {32'h0, p1_q} + {15'h0, mid_sum, 16'h0} + {mul_p1, 32'h0};
  assign u_hi        = u_full[63:32];
  assign u_lo_unused = ^u_full[31:0];

  always_comb begin
    hi_res = u_hi;
    case (op_q)
      OP_MULXUU: hi_res = u_hi;
      OP_MULXSS: hi_res = u_hi - (a_q[31] ? b_q : 32'h0) - (b_q[31] ? a_q : 32'h0);
      OP_MULXSU: hi_res = u_hi - (a_q[31] ? b_q : 32'h0);
      default:   hi_res = u_hi;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_en    = 1'b0;
    mul_src1  = a_q;
    mul_src2  = b_q;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        mul_src1 = 32'h0;
        mul_src2 = 32'h0;
        in_ready = up_q & ~flush;
        if (in_valid && in_ready) begin
          a_d     = in_src1;
          b_d     = in_src2;
          op_d    = in_op;
          state_d = S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        mul_en = 1'b1;
        if (MUL_LATENCY > 1) begin
          cnt_d   = WAIT1_LD;
          state_d = S_WAIT1;
        end else begin
          state_d = S_ISSUE2;
        end
      end
      S_WAIT1: begin
        if (cnt_q == 2'd0) state_d = S_ISSUE2;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_ISSUE2: begin
        p1_d = mul_p1;
        p2_d = mul_p2;
        p3_d = mul_p3;
        if (op_q == OP_MUL) begin
          result_d = mul_lo;
          state_d  = S_DONE;
        end else begin
          mul_src1 = {16'h0, a_q[31:16]};
          mul_src2 = {16'h0, b_q[31:16]};
          mul_en   = 1'b1;
          cnt_d    = WAIT2_LD;
          state_d  = S_WAIT2;
        end
      end
      S_WAIT2: begin
        if (cnt_q == 2'd0) begin
          result_d = hi_res;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a result being consumed this cycle.
    if (flush && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      cnt_d     = 2'd0;
      result_d  = result_q;
      mul_en    = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 2'b00;
      p1_q     <= 32'h0;
      p2_q     <= 32'h0;
      p3_q     <= 32'h0;
      result_q <= 32'h0;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      result_q <= result_d;
      up_q     <= 1'b1;
    end
  end

  assign out_result = result_q;

endmodule

// File: tb/tb_cq_viola_nios2_s_cpu_mult_seq.sv
// Bench for the multiply sequencer: one instance per legal latency (lane 0 = L1, lane 1 = L2),
// each with a behavioural multiplier cell; results checked against plain 64-bit arithmetic.
module tb_cq_viola_nios2_s_cpu_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_src1 [2];
  logic [31:0] in_src2 [2];
  logic [1:0]  in_op [2];
  logic        flush [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_result [2];
  logic        busy [2];
  logic [31:0] mul_src1 [2];
  logic [31:0] mul_src2 [2];
  logic        mul_en [2];
  logic [31:0] mul_p1 [2];
  logic [31:0] mul_p2 [2];
  logic [31:0] mul_p3 [2];

  int passed = 0;
  int total  = 0;
  int lane_l = 1;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [31:0] s_p1, s_p2, s_p3, d_p1, d_p2, d_p3;

    cq_viola_nios2_s_cpu_mult_seq #(.MUL_LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_src1    (in_src1[g]),
      .in_src2    (in_src2[g]),
      .in_op      (in_op[g]),
      .flush      (flush[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_result (out_result[g]),
      .busy       (busy[g]),
      .mul_src1   (mul_src1[g]),
      .mul_src2   (mul_src2[g]),
      .mul_en     (mul_en[g]),
      .mul_p1     (mul_p1[g]),
      .mul_p2     (mul_p2[g]),
      .mul_p3     (mul_p3[g])
    );

    // Cell: products registered on mul_en, plus one free-running stage when L=2.
    always @(posedge clk) begin
      if (mul_en[g]) begin
        s_p1 <= {16'h0, mul_src1[g][15:0]}  * {16'h0, mul_src2[g][15:0]};
        s_p2 <= {16'h0, mul_src1[g][15:0]}  * {16'h0, mul_src2[g][31:16]};
        s_p3 <= {16'h0, mul_src1[g][31:16]} * {16'h0, mul_src2[g][15:0]};
      end
      d_p1 <= s_p1;
      d_p2 <= s_p2;
      d_p3 <= s_p3;
    end

    assign mul_p1[g] = (g == 0) ? s_p1 : d_p1;
    assign mul_p2[g] = (g == 0) ? s_p2 : d_p2;
    assign mul_p3[g] = (g == 0) ? s_p3 : d_p3;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b10:   p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'b11:   p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
      default: p = {32'h0, a} * {32'h0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (L=%0d): got %0h, expected %0h", name, lane_l, act, exp);
  endtask

  // Entered and left just after a rising edge with the lane idle.
  task automatic do_op(input int k, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int          lat;
    int          en_cnt;
    bit          ok;
    bit          stable;
    logic [31:0] res;
    in_valid[k] = 1'b1;
    in_op[k]    = op;
    in_src1[k]  = a;
    in_src2[k]  = b;
    out_ready[k] = 1'b0;
    @(negedge clk);
    check("accept", in_ready[k], 1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    lat = 1; en_cnt = 0; ok = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (mul_en[k]) en_cnt++;
      if (out_valid[k]) begin ok = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!ok) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    res = out_result[k];
    check("result", res, exp);
    check("latency", lat, (op == 2'b00) ? 2 + lane_l : 2 + 2 * lane_l);
    check("mul_en_cycles", en_cnt, (op == 2'b00) ? 1 : 2);
    if (hold > 0) begin
      stable = 1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (!(out_valid[k] && out_result[k] == res && !in_ready[k] && !mul_en[k])) stable = 0;
      end
      check("hold_stable", stable, 1);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    check("idle_after_consume", {busy[k], out_valid[k], in_ready[k]}, 3'b001);
    @(posedge clk); #1;
  endtask

  task automatic flush_seqs(input int k);
    int          seen;
    logic [31:0] a, b;
    // Flush during WAIT2
    a = $urandom; b = $urandom;
    in_valid[k] = 1'b1; in_op[k] = 2'b01; in_src1[k] = a; in_src2[k] = b;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    repeat (1 + lane_l) @(posedge clk);
    #1;
    flush[k] = 1'b1;
    @(negedge clk);
    check("flush_wait2_cycle", {busy[k], mul_en[k], out_valid[k]}, 3'b100);
    @(posedge clk); #1;
    flush[k] = 1'b0;
    @(negedge clk);
    check("flush_wait2_next", {busy[k], in_ready[k]}, 2'b01);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid[k]) seen++;
    end
    check("flush_no_out_valid", seen, 0);
    @(posedge clk); #1;
    do_op(k, 2'b10, a, b, model(2'b10, a, b), 0);

    // Flush in DONE overrides a simultaneous consume
    a = $urandom; b = $urandom;
    in_valid[k] = 1'b1; in_op[k] = 2'b00; in_src1[k] = a; in_src2[k] = b;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    repeat (1 + lane_l) @(posedge clk);
    #1;
    @(negedge clk);
    check("done_reached", out_valid[k], 1);
    flush[k] = 1'b1; out_ready[k] = 1'b1;
    #1;
    check("flush_done_no_valid", out_valid[k], 0);
    @(posedge clk); #1;
    flush[k] = 1'b0; out_ready[k] = 1'b0;
    @(negedge clk);
    check("flush_done_idle", {busy[k], out_valid[k]}, 2'b00);

    // Flush with a request in IDLE must not accept
    @(posedge clk); #1;
    in_valid[k] = 1'b1; flush[k] = 1'b1; in_op[k] = 2'b00;
    @(negedge clk);
    check("flush_idle_in_ready", in_ready[k], 0);
    @(posedge clk); #1;
    in_valid[k] = 1'b0; flush[k] = 1'b0;
    @(negedge clk);
    check("flush_idle_not_busy", busy[k], 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_seq(input int k);
    int          seen;
    logic [31:0] a, b;
    a = 32'h8765_4321; b = 32'hFEDC_BA98;
    in_valid[k] = 1'b1; in_op[k] = 2'b10; in_src1[k] = a; in_src2[k] = b;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    repeat (lane_l) @(posedge clk);
    #1;
    @(negedge clk);
    check("issue2_mul_en", mul_en[k], 1);
    check("issue2_src1_hi", mul_src1[k], {16'h0, a[31:16]});
    check("issue2_src2_hi", mul_src2[k], {16'h0, b[31:16]});
    reset_n[k] = 1'b0;
    #1;
    check("reset_mid_outputs",
          {in_ready[k], out_valid[k], busy[k], mul_en[k], mul_src1[k], mul_src2[k], out_result[k]},
          0);
    @(posedge clk); #1;
    reset_n[k] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[k]) seen++;
    end
    check("reset_no_out_valid", seen, 0);
    @(posedge clk); #1;
    do_op(k, 2'b11, a, b, model(2'b11, a, b), 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b0; in_valid[k] = 1'b0; in_src1[k] = '0; in_src2[k] = '0;
      in_op[k] = '0; flush[k] = 1'b0; out_ready[k] = 1'b0;
    end
    vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[6] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[7] = '{2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      lane_l = k + 1;
      check("reset_outputs",
            {in_ready[k], out_valid[k], busy[k], mul_en[k], mul_src1[k], mul_src2[k], out_result[k]},
            0);
    end
    @(posedge clk); #1;
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      lane_l = k + 1;
      check("in_ready_after_release", in_ready[k], 1);
    end
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      lane_l = k + 1;
      for (int i = 0; i < 8; i++) do_op(k, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
      do_op(k, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 5);
      for (int i = 0; i < 25; i++) begin
        logic [1:0]  op;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        if (i % 5 == 0) a[31] = 1'b1;
        if (i % 7 == 0) b[31] = 1'b1;
        do_op(k, op, a, b, model(op, a, b), int'($urandom_range(0, 2)));
      end
      flush_seqs(k);
      reset_seq(k);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
